fetch_exec_responder: RTL

//  Datapath-side responder to the 3-bit fetch/execute control state machine (cs).

---
 rtl/fetch_exec_responder.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_exec_responder.sv
// Datapath responder to the fetch/execute controller: follows cs, fetches a two-half
// instruction from a combinational ROM, executes it and reports halt/cont during EXECA.
module fetch_exec_responder #(
  parameter int unsigned HALF_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned COUNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            cs_i,
  input  logic [HALF_W-1:0]     mem_rdata_i,
  output logic [ADDR_W:0]       mem_addr_o,
  output logic                  halt_o,
  output logic                  cont_o,
  output logic [ADDR_W-1:0]     pc_o,
  output logic [2*HALF_W-1:0]   ir_o,
  output logic [HALF_W-1:0]     acc_o,
  output logic [COUNT_W-1:0]    exec_cnt_o,
  output logic                  err_o
);

  localparam int unsigned IrW = 2 * HALF_W;

  localparam logic [2:0] CsIdle   = 3'b000;
  localparam logic [2:0] CsFetchA = 3'b001;
  localparam logic [2:0] CsFetchB = 3'b010;
  localparam logic [2:0] CsExecA  = 3'b011;
  localparam logic [2:0] CsExecB  = 3'b100;

  typedef enum logic [1:0] {OpNop, OpAdd, OpHalt, OpJump} op_e;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [IrW-1:0]     ir_q, ir_d;
  logic [HALF_W-1:0]  acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               half_sel, halt, cont;
  op_e                op;

  assign op = op_e'(ir_q[IrW-1 -: 2]);

  // Unmatched cs (including X/Z) falls into default: flag error, hold state.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    half_sel = 1'b0;
    halt     = 1'b0;
    cont     = 1'b0;
    case (cs_i)
      CsIdle: begin
      end
      CsFetchA: begin
        ir_d[IrW-1:HALF_W] = mem_rdata_i;
      end
      CsFetchB: begin
        half_sel           = 1'b1;
        ir_d[HALF_W-1:0]   = mem_rdata_i;
        pc_d               = pc_q + ADDR_W'(1);
      end
      CsExecA: begin
        if (cnt_q != {COUNT_W{1'b1}}) cnt_d = cnt_q + COUNT_W'(1);
        if (op == OpJump) pc_d = ir_q[ADDR_W-1:0];
        halt = (op == OpHalt);
        cont = (op == OpAdd);
      end
      CsExecB: begin
        if (op == OpAdd) acc_d = acc_q + ir_q[HALF_W-1:0];
      end
      default: begin
        err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_addr_o = {pc_q, half_sel};
  assign halt_o     = halt;
  assign cont_o     = cont;
  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign acc_o      = acc_q;
  assign exec_cnt_o = cnt_q;
  assign err_o      = err_q;

endmodule
